// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative 32-bit signed multiply (shift-add) / divide (restoring), 32 steps per op.
module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t      r_state, w_state_nxt;
  logic [4:0]  r_count;
  logic [63:0] r_a, r_acc;
  logic [31:0] r_b, r_rem, r_quo, r_result;
  logic        r_neg, r_bzero, r_exc, r_rdy;
  logic        w_start, w_step, w_mul, w_last, w_ge;
  logic [31:0] w_abs_a, w_abs_b, w_rem_nxt, w_quo_nxt, w_quo_s, w_res;
  logic [32:0] w_rem_sh;
  logic [63:0] w_acc_nxt, w_prod;
  logic        w_exc;
  assign w_start   = ctrl_MULT | ctrl_DIV;
  assign w_mul     = r_state == MUL;
  assign w_step    = w_mul | (r_state == DIV);
  assign w_last    = w_step && r_count == 5'd31;
  assign w_abs_a   = data_operandA[31] ? -data_operandA : data_operandA;
  assign w_abs_b   = data_operandB[31] ? -data_operandB : data_operandB;
  assign w_acc_nxt = r_acc + (r_b[0] ? r_a : 64'd0);
  assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_rem_sh  = {r_rem, r_a[31]};
  assign w_ge      = w_rem_sh >= {1'b0, r_b};
  assign w_rem_nxt = w_ge ? 32'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_ge};
  assign w_quo_s   = r_neg ? -w_quo_nxt : w_quo_nxt;
  // a positive quotient with bit 31 set can only come from -2^31 / -1
  assign w_res = w_mul ? w_prod[31:0] : r_bzero ? 32'd0 : w_quo_s;
  assign w_exc = w_mul ? ~(&w_prod[63:31] | ~|w_prod[63:31]) : r_bzero | (~r_neg & w_quo_nxt[31]);
  always_comb begin
    w_state_nxt = IDLE;
    w_state_nxt = ctrl_MULT ? MUL : ctrl_DIV ? DIV : w_last ? DONE : w_step ? r_state : IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_neg    <= 1'b0;
      r_bzero  <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= w_last;
      if (w_last) begin
        r_result <= w_res;
        r_exc    <= w_exc;
      end
      if (w_start) begin
        r_count <= '0;
        r_neg   <= data_operandA[31] ^ data_operandB[31];
        r_bzero <= data_operandB == 32'd0;
        r_a     <= {32'd0, w_abs_a};
        r_b     <= w_abs_b;
        r_acc   <= '0;
        r_rem   <= '0;
        r_quo   <= '0;
      end else if (w_step) begin
        r_count <= r_count + 5'd1;
        r_a     <= r_a << 1;
        r_b     <= w_mul ? r_b >> 1 : r_b;
        r_acc   <= w_mul ? w_acc_nxt : r_acc;
        r_rem   <= w_mul ? r_rem : w_rem_nxt;
        r_quo   <= w_mul ? r_quo : w_quo_nxt;
      end
    end
  end
  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = w_step;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed vectors, scoreboard queue checked by a monitor on each RDY pulse.
module tb_multdiv_unit;
  logic        clock = 1'b0, reset = 1'b1, ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0, data_result;
  logic        data_exception, data_resultRDY, busy;
  typedef struct {logic [31:0] r; logic e; int c;} exp_t;
  exp_t sb[$];
  int cyc = 0, vectors = 0, errors = 0, e0 = 0;
  multdiv_unit dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      if (sb.size() == 0) chk("unexpected_rdy", 32'd1, 32'd0);
      else begin
        exp_t x;
        x = sb.pop_front();
        chk("rdy_cycle", cyc, x.c);
        chk("result", data_result, x.r);
        chk("exception", 32'(data_exception), 32'(x.e));
      end
    end
  end
  task automatic start(input logic m, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic e);
    exp_t x;
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = ~m; data_operandA = a; data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    e0 = cyc;
    x.r = r; x.e = e; x.c = cyc + 32;
    sb.push_back(x);
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (sb.size() != 0) chk("rdy_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (3) @(negedge clock);
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_result"}, data_result, 32'd0);
    chk({n, "_exception"}, 32'(data_exception), 32'd0);
    chk({n, "_rdy"}, 32'(data_resultRDY), 32'd0);
    chk({n, "_busy"}, 32'(busy), 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    start(1'b1, 32'd6, 32'd7, 32'h0000002A, 1'b0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      chk("busy_high", 32'(busy), 32'd1);
    end
    @(negedge clock);
    chk("busy_low_e32", 32'(busy), 32'd0);
    drain();
    start(1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0); drain();
    start(1'b1, 32'h00010000, 32'h00010000, 32'h0, 1'b1); drain();
    start(1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0); drain();
    start(1'b0, 32'd100, 32'hFFFFFFF6, 32'hFFFFFFF6, 1'b0); drain();
    start(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1); drain();
    start(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1); drain();
    start(1'b0, 32'd5, 32'd0, 32'd0, 1'b1); drain();
    start(1'b1, 32'd2, 32'd3, 32'd6, 1'b0); drain();
    repeat (5) @(negedge clock);
    chk("hold_result", data_result, 32'd6);
    chk("hold_exception", 32'(data_exception), 32'd0);
    // back-to-back: second start on the very edge the first one completes
    start(1'b0, 32'h7FFFFFFF, 32'h10, 32'h07FFFFFF, 1'b0);
    repeat (31) @(posedge clock);
    start(1'b1, 32'h80000000, 32'd1, 32'h80000000, 1'b0);
    drain();
    // restart at E10 drops the multiply
    start(1'b1, 32'd6, 32'd7, 32'h2A, 1'b0);
    repeat (9) @(posedge clock);
    void'(sb.pop_back());
    start(1'b0, 32'd9, 32'd3, 32'd3, 1'b0);
    chk("restart_edge", cyc, e0);
    drain();
    // async reset mid-operation
    start(1'b1, 32'd6, 32'd7, 32'h2A, 1'b0);
    repeat (15) @(posedge clock);
    #2;
    sb.delete();
    reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    start(1'b1, 32'd4, 32'd4, 32'd16, 1'b0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
